noc_out_port_arbiter: RTL

Round-robin arbiter and packet sequencer for one output direction of a mesh `neuron_cell` router. It shares a single 4-bit output link among the five requesters (north, south, east, west, local) and locks the link to the winner for a whole fixed-length packet. It honours the downstream `neighbor_full` backpressure and drives the `write_req`/data pair toward the neighbouring cell. Each router instantiates four of these arbiters, one per mesh direction.

---
 rtl/noc_out_port_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/noc_out_port_arbiter.sv
// Round-robin output-port arbiter that locks one requester for a whole packet.
// Optional build macro NOC_ARB_LOCAL_PRIO_EN gives the local requester fixed priority in IDLE.
module noc_out_port_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int FLIT_W    = 4,
  parameter int PKT_FLITS = 4,
  parameter int CNT_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*FLIT_W-1:0] flit_in,
  input  logic                      neighbor_full,
  output logic [NUM_REQ-1:0]        pop,
  output logic [FLIT_W-1:0]         data_out,
  output logic                      write_req,
  output logic                      busy,
  output logic [2:0]                grant_id
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
  logic [FLIT_W-1:0]  data_out_q, data_out_d;
  logic               write_req_q, write_req_d;
  logic               xfer;

  // First asserted request strictly after ptr, wrapping modulo NUM_REQ.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                         input logic [2:0]         ptr);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign xfer = (state_q == XFER) && req[grant_id_q] && !neighbor_full;

  always_comb begin
    pop             = '0;
    pop[grant_id_q] = xfer;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    flit_cnt_d  = flit_cnt_q;
    data_out_d  = data_out_q;
    write_req_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
`ifdef NOC_ARB_LOCAL_PRIO_EN
          if (req[NUM_REQ-1]) grant_id_d = 3'(NUM_REQ-1);
          else                grant_id_d = rr_pick(req, rr_ptr_q);
`else
          grant_id_d = rr_pick(req, rr_ptr_q);
`endif
          flit_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          data_out_d  = flit_in[int'(grant_id_q)*FLIT_W +: FLIT_W];
          write_req_d = 1'b1;
          flit_cnt_d  = flit_cnt_q + 1'b1;
          // Exact compare on the pre-increment count, so PKT_FLITS == 2^CNT_W never wraps early.
          if (flit_cnt_q == CNT_W'(PKT_FLITS-1)) begin
            state_d = IDLE;
`ifdef NOC_ARB_LOCAL_PRIO_EN
            if (grant_id_q != 3'(NUM_REQ-1)) rr_ptr_d = grant_id_q;
`else
            rr_ptr_d = grant_id_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 3'(NUM_REQ-1);
      grant_id_q  <= '0;
      flit_cnt_q  <= '0;
      data_out_q  <= '0;
      write_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      flit_cnt_q  <= flit_cnt_d;
      data_out_q  <= data_out_d;
      write_req_q <= write_req_d;
    end
  end

  assign data_out  = data_out_q;
  assign write_req = write_req_q;
  assign busy      = (state_q == XFER);
  assign grant_id  = grant_id_q;

endmodule
